// File: rtl/pe_bus_pkg.sv
// pe_bus_pkg: shared widths, register-select encodings and FSM states for the PE bus responder
package pe_bus_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 1 << REG_W;
  typedef enum logic {SEL_A = 1'b0, SEL_AB = 1'b1} reg_sel_t;
  typedef enum logic [1:0] {IDLE, GRANTED, MEM_WAIT, MEM_DONE} state_t;
  function automatic int wrap_inc(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/pe_bus_responder_if.sv
// pe_bus_responder_if: shared PE bus between the PE array (master) and the responder (slave)
interface pe_bus_responder_if #(parameter int NUM_PE = 4);
  import pe_bus_pkg::*;
  logic [NUM_PE-1:0] bus_request;
  logic [NUM_PE-1:0] grant;
  logic [DATA_W-1:0] mem_addressBus;
  logic [DATA_W-1:0] result_outBus;
  logic [DATA_W-1:0] PCoutBus;
  logic [REG_W-1:0] rs1OutBus;
  logic [REG_W-1:0] rs2OutBus;
  logic [REG_W-1:0] rdOutBus;
  logic reg_selectBus;
  logic read_enBus;
  logic rd_writeBus;
  logic mem_readBus;
  logic mem_writeBus;
  logic [DATA_W-1:0] AmuxBus;
  logic [DATA_W-1:0] BmuxBus;
  logic data_ReadyBus;
  logic [DATA_W-1:0] memData;
  logic mem_ackBus;
  logic [DATA_W-1:0] pc_out;
  logic pc_valid;
  modport master (
    output bus_request, mem_addressBus, result_outBus, PCoutBus, rs1OutBus, rs2OutBus, rdOutBus,
           reg_selectBus, read_enBus, rd_writeBus, mem_readBus, mem_writeBus,
    input  grant, AmuxBus, BmuxBus, data_ReadyBus, memData, mem_ackBus, pc_out, pc_valid
  );
  modport slave (
    input  bus_request, mem_addressBus, result_outBus, PCoutBus, rs1OutBus, rs2OutBus, rdOutBus,
           reg_selectBus, read_enBus, rd_writeBus, mem_readBus, mem_writeBus,
    output grant, AmuxBus, BmuxBus, data_ReadyBus, memData, mem_ackBus, pc_out, pc_valid
  );
endinterface

// File: rtl/pe_bus_responder_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr, wrapping
module rr_arbiter #(
  parameter int NUM_PE = 4,
  localparam int PW = $clog2(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_PE-1:0] gnt,
  output logic [PW-1:0]     idx,
  output logic              any
);
  logic [PW-1:0] k;
  always_comb begin
    any = 1'b0;
    idx = '0;
    k = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      k = PW'((int'(ptr) + i) % NUM_PE);
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
    gnt = any ? NUM_PE'(1) << idx : '0;
  end
endmodule

// File: rtl/pe_bus_responder.sv
// pe_bus_responder: PE bus target - round-robin grant, local register file and global memory service
module pe_bus_responder
  import pe_bus_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  pe_bus_responder_if.slave bus
);
  localparam int PW = $clog2(NUM_PE);
  localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  state_t st_q, st_d;
  logic [NUM_PE-1:0] grant_q, grant_d, arb_gnt;
  logic [PW-1:0] rr_q, rr_d, own_q, own_d, arb_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0] widx_q, widx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, amux_q, amux_d, bmux_q, bmux_d;
  logic [DATA_W-1:0] mdata_q, mdata_d, pc_q, pc_d;
  logic wr_q, wr_d, rdy_q, rdy_d, ack_q, ack_d, pcv_q, pcv_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic arb_any, mem_we, in_range, own_req, rel, unused_addr;
  rr_arbiter #(.NUM_PE(NUM_PE)) u_arb (
    .req(bus.bus_request),
    .ptr(rr_q),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  assign in_range = widx_q < 30'(MEM_DEPTH);
  assign own_req = bus.bus_request[own_q];
  assign unused_addr = ^bus.mem_addressBus[1:0];
  // Memory access is performed on the edge that enters MEM_DONE, so ack and data appear together.
  always_comb begin
    st_d = st_q;
    grant_d = grant_q;
    rr_d = rr_q;
    own_d = own_q;
    cnt_d = cnt_q;
    widx_d = widx_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    amux_d = amux_q;
    bmux_d = bmux_q;
    rdy_d = 1'b0;
    mdata_d = mdata_q;
    ack_d = 1'b0;
    pc_d = pc_q;
    pcv_d = 1'b0;
    regs_d = regs_q;
    mem_we = 1'b0;
    rel = 1'b0;
    case (st_q)
      IDLE:
        if (arb_any) begin
          grant_d = arb_gnt;
          own_d = arb_idx;
          st_d = GRANTED;
        end
      GRANTED:
        if (bus.mem_writeBus || bus.mem_readBus) begin
          widx_d = bus.mem_addressBus[31:2];
          wdata_d = bus.result_outBus;
          wr_d = bus.mem_writeBus;
          cnt_d = CW'(MEM_LATENCY - 1);
          st_d = MEM_WAIT;
        end else begin
          if (bus.read_enBus) begin
            amux_d = regs_q[bus.rs1OutBus];
            bmux_d = reg_sel_t'(bus.reg_selectBus) == SEL_AB ? regs_q[bus.rs2OutBus] : '0;
            rdy_d = 1'b1;
          end
          if (bus.rd_writeBus && bus.rdOutBus != '0) regs_d[bus.rdOutBus] = bus.result_outBus;
          rel = !own_req;
        end
      MEM_WAIT:
        if (cnt_q == '0) begin
          mem_we = wr_q && in_range;
          mdata_d = wr_q ? mdata_q : (in_range ? mem[widx_q[AW-1:0]] : '0);
          ack_d = 1'b1;
          st_d = MEM_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      MEM_DONE:
        if (own_req) st_d = GRANTED;
        else rel = 1'b1;
      default: st_d = IDLE;
    endcase
    if (rel) begin
      grant_d = '0;
      pc_d = bus.PCoutBus;
      pcv_d = 1'b1;
      rr_d = PW'(wrap_inc(int'(own_q), NUM_PE));
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
      widx_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      amux_q <= '0;
      bmux_q <= '0;
      rdy_q <= 1'b0;
      mdata_q <= '0;
      ack_q <= 1'b0;
      pc_q <= '0;
      pcv_q <= 1'b0;
      regs_q <= '0;
    end else begin
      st_q <= st_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      widx_q <= widx_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      amux_q <= amux_d;
      bmux_q <= bmux_d;
      rdy_q <= rdy_d;
      mdata_q <= mdata_d;
      ack_q <= ack_d;
      pc_q <= pc_d;
      pcv_q <= pcv_d;
      regs_q <= regs_d;
    end
  always_ff @(posedge clk)
    if (mem_we) mem[widx_q[AW-1:0]] <= wdata_q;
  assign bus.grant = grant_q;
  assign bus.AmuxBus = amux_q;
  assign bus.BmuxBus = bmux_q;
  assign bus.data_ReadyBus = rdy_q;
  assign bus.memData = mdata_q;
  assign bus.mem_ackBus = ack_q;
  assign bus.pc_out = pc_q;
  assign bus.pc_valid = pcv_q;
endmodule

// File: tb/tb_pe_bus_responder.sv
// tb_pe_bus_responder: directed plus randomized checks against a behavioural bus/regfile/memory model
module tb_pe_bus_responder;
  localparam int NPE = 4;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int owner = 0;
  int m_ptr = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [int];
  int wq[$];
  logic [31:0] m_mdata, m_a, m_b;
  pe_bus_responder_if #(.NUM_PE(NPE)) bus ();
  pe_bus_responder #(.NUM_PE(NPE), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish, required $finish before timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_cmd();
    bus.read_enBus = 1'b0;
    bus.rd_writeBus = 1'b0;
    bus.mem_readBus = 1'b0;
    bus.mem_writeBus = 1'b0;
  endtask
  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_ptr = 0;
    m_mdata = 32'h0;
    m_a = 32'h0;
    m_b = 32'h0;
  endtask
  function automatic int pick(input logic [3:0] mask);
    for (int i = 0; i < NPE; i++) if (mask[(m_ptr + i) % NPE]) return (m_ptr + i) % NPE;
    return -1;
  endfunction
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
    chk({tag, "_ack"}, 32'(bus.mem_ackBus), 32'h0);
    chk({tag, "_ready"}, 32'(bus.data_ReadyBus), 32'h0);
    chk({tag, "_amux"}, bus.AmuxBus, 32'h0);
    chk({tag, "_bmux"}, bus.BmuxBus, 32'h0);
    chk({tag, "_memData"}, bus.memData, 32'h0);
    chk({tag, "_pc_out"}, bus.pc_out, 32'h0);
    chk({tag, "_pc_valid"}, 32'(bus.pc_valid), 32'h0);
  endtask
  task automatic acquire(input logic [3:0] mask);
    int w;
    w = pick(mask);
    bus.bus_request = mask;
    tick();
    chk("grant", 32'(bus.grant), 32'(1) << w);
    owner = w;
  endtask
  task automatic release_bus();
    logic [31:0] pc;
    pc = $urandom;
    bus.PCoutBus = pc;
    bus.bus_request[owner] = 1'b0;
    tick();
    chk("release_grant", 32'(bus.grant), 32'h0);
    chk("pc_valid", 32'(bus.pc_valid), 32'h1);
    chk("pc_out", bus.pc_out, pc);
    m_ptr = (owner + 1) % NPE;
  endtask
  task automatic reg_op(input int re, input int we, input int rs1, input int rs2, input int sel,
                        input int rd, input logic [31:0] d);
    bus.read_enBus = 1'(re);
    bus.rd_writeBus = 1'(we);
    bus.rs1OutBus = 5'(rs1);
    bus.rs2OutBus = 5'(rs2);
    bus.reg_selectBus = 1'(sel);
    bus.rdOutBus = 5'(rd);
    bus.result_outBus = d;
    tick();
    clr_cmd();
    if (re != 0) begin
      m_a = m_regs[rs1];
      m_b = (sel != 0) ? m_regs[rs2] : 32'h0;
    end
    if (we != 0 && rd != 0) m_regs[rd] = d;
    chk("data_ready", 32'(bus.data_ReadyBus), (re != 0) ? 32'h1 : 32'h0);
    chk("AmuxBus", bus.AmuxBus, m_a);
    chk("BmuxBus", bus.BmuxBus, m_b);
    tick();
    chk("ready_pulse", 32'(bus.data_ReadyBus), 32'h0);
  endtask
  task automatic mem_op(input int wr, input int rdf, input logic [31:0] addr, input logic [31:0] d,
                        input int drop);
    int k;
    int idx;
    logic [31:0] pc;
    idx = int'(addr[31:2]);
    pc = $urandom;
    bus.PCoutBus = pc;
    bus.mem_addressBus = addr;
    bus.result_outBus = d;
    bus.mem_writeBus = 1'(wr);
    bus.mem_readBus = 1'(rdf);
    bus.read_enBus = 1'b1;
    bus.rs1OutBus = 5'd7;
    bus.rd_writeBus = 1'b1;
    bus.rdOutBus = 5'd7;
    tick();
    clr_cmd();
    if (drop != 0) bus.bus_request[owner] = 1'b0;
    chk("mem_cmd_no_ready", 32'(bus.data_ReadyBus), 32'h0);
    k = 0;
    for (int i = 2; i <= 12; i++) begin
      tick();
      if (bus.mem_ackBus === 1'b1) begin
        k = i;
        break;
      end
    end
    chk("ack_latency", 32'(k), 32'(LAT + 1));
    if (wr != 0) begin
      if (idx < DEPTH) begin
        m_mem[idx] = d;
        wq.push_back(idx);
      end
    end else begin
      m_mdata = (idx < DEPTH) ? m_mem[idx] : 32'h0;
    end
    chk("memData", bus.memData, m_mdata);
    tick();
    chk("ack_pulse", 32'(bus.mem_ackBus), 32'h0);
    if (drop != 0) begin
      chk("mem_release_grant", 32'(bus.grant), 32'h0);
      chk("mem_pc_valid", 32'(bus.pc_valid), 32'h1);
      chk("mem_pc_out", bus.pc_out, pc);
      m_ptr = (owner + 1) % NPE;
    end else begin
      chk("grant_held", 32'(bus.grant), 32'(1) << owner);
    end
  endtask
  initial begin
    bus.bus_request = '0;
    bus.mem_addressBus = '0;
    bus.result_outBus = '0;
    bus.PCoutBus = '0;
    bus.rs1OutBus = '0;
    bus.rs2OutBus = '0;
    bus.rdOutBus = '0;
    bus.reg_selectBus = 1'b0;
    clr_cmd();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();
    chk("idle_no_request", 32'(bus.grant), 32'h0);
    acquire(4'b0001);
    reg_op(0, 1, 0, 0, 0, 5, 32'hDEADBEEF);
    reg_op(1, 0, 5, 0, 1, 0, 32'h0);
    reg_op(1, 1, 5, 5, 1, 5, 32'h0BADF00D);
    reg_op(1, 0, 5, 5, 0, 0, 32'h0);
    reg_op(0, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    reg_op(1, 0, 0, 0, 1, 0, 32'h0);
    for (int i = 0; i < 24; i++)
      reg_op($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
    mem_op(1, 0, 32'h10, 32'h12345678, 0);
    mem_op(0, 1, 32'h10, 32'h0, 0);
    mem_op(0, 1, 32'h13, 32'h0, 0);
    mem_op(1, 0, 32'(4 * DEPTH), 32'hCAFEF00D, 0);
    mem_op(0, 1, 32'(4 * DEPTH), 32'h0, 0);
    mem_op(0, 1, 32'h10, 32'h0, 0);
    mem_op(1, 1, 32'h20, 32'hA5A5C3C3, 0);
    mem_op(0, 1, 32'h20, 32'h0, 0);
    for (int i = 0; i < 12; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      if (op == 2 && wq.size() > 0) begin
        a = (32'(wq[$urandom_range(0, wq.size() - 1)]) << 2) | 32'($urandom_range(0, 3));
        mem_op(0, 1, a, 32'h0, 0);
      end else if (op == 3) begin
        a = (32'(DEPTH + $urandom_range(0, 5000)) << 2) | 32'($urandom_range(0, 3));
        mem_op($urandom_range(0, 1), 1, a, $urandom, 0);
      end else begin
        a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
        mem_op(1, 0, a, $urandom, 0);
      end
    end
    reg_op(1, 0, 7, 7, 1, 0, 32'h0);
    release_bus();
    for (int r = 0; r < 13; r++) begin
      logic [3:0] mask;
      mask = (r < 5) ? 4'hF : 4'($urandom_range(1, 15));
      acquire(mask);
      reg_op(0, 1, 0, 0, 0, $urandom_range(1, 7), $urandom);
      chk("no_preempt", 32'(bus.grant), 32'(1) << owner);
      release_bus();
    end
    acquire(4'b0010);
    mem_op(1, 0, 32'h100, 32'h5EED1234, 1);
    acquire(4'b0100);
    mem_op(0, 1, 32'h100, 32'h0, 0);
    release_bus();
    acquire(4'b0100);
    bus.mem_addressBus = 32'h100;
    bus.result_outBus = 32'hBAD0BAD0;
    bus.mem_writeBus = 1'b1;
    tick();
    clr_cmd();
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    chk_idle_outputs("reset_midop");
    bus.bus_request = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acquire(4'b1111);
    mem_op(0, 1, 32'h100, 32'h0, 0);
    reg_op(1, 0, 5, 0, 0, 0, 32'h0);
    release_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_bus_responder.md
Name: pe_bus_responder

Overview:
- Bus-side responder for the shared PE bus: the target end of the PE bus-interface protocol.
- Arbitrates `bus_request` from NUM_PE processing elements round-robin and drives a one-hot `grant`.
- Services the granted PE's commands: local register-file reads (`AmuxBus`/`BmuxBus` + `data_ReadyBus`), register writes (`rd_writeBus`), and global-memory reads/writes (`memData` + `mem_ackBus`).
- Sits between the PE array and the local register file / global data memory, both held internally.

Parameters:
- NUM_PE, 4, number of requesting PEs (≥2)
- MEM_DEPTH, 1024, global memory depth in 32-bit words
- MEM_LATENCY, 2, wait cycles between memory command capture and ack (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_request  in  NUM_PE  per-PE bus request
- grant  out  NUM_PE  one-hot grant, at most one bit set
- mem_addressBus  in  32  byte address for global memory
- result_outBus  in  32  write data (register or memory)
- PCoutBus  in  32  PC from granted PE
- rs1OutBus  in  5  read register index A
- rs2OutBus  in  5  read register index B
- rdOutBus  in  5  write register index
- reg_selectBus  in  1  0: read rs1 only; 1: read rs1 and rs2
- read_enBus  in  1  register read command
- rd_writeBus  in  1  register write command
- mem_readBus  in  1  global memory read command
- mem_writeBus  in  1  global memory write command
- AmuxBus  out  32  rs1 read data
- BmuxBus  out  32  rs2 read data (0 when reg_select=0)
- data_ReadyBus  out  1  one-cycle pulse, register read data valid
- memData  out  32  memory read data, held until next read completes
- mem_ackBus  out  1  one-cycle pulse, memory operation complete
- pc_out  out  32  PCoutBus captured at release
- pc_valid  out  1  one-cycle pulse with pc_out

Behaviour:
- Reset: all outputs 0, FSM=IDLE, RR pointer=0, register file cleared to 0. Memory contents are not reset.
- FSM states: IDLE, GRANTED, MEM_WAIT, MEM_DONE.
- IDLE:
  - If any request is present, pick the first requester at or after the RR pointer (wrapping).
  - Assert its grant bit at the next edge; go to GRANTED.
  - No request: stay in IDLE, grant=0.
- GRANTED: commands are sampled every cycle. Bus inputs are honoured only while in GRANTED.
  - mem_write or mem_read, write wins if both are set:
    - Latch address, data and op; load wait counter with MEM_LATENCY-1; go to MEM_WAIT.
    - read_en/rd_write in the same cycle are ignored.
  - Otherwise read_en and rd_write are serviced in the same cycle; both may occur together.
  - read_en:
    - Next cycle AmuxBus=reg[rs1], BmuxBus=reg_select?reg[rs2]:0, data_ReadyBus=1 for one cycle.
    - Outputs hold until the next read.
    - Read sees the pre-write value (no bypass).
  - rd_write: reg[rd]=result_outBus at the edge. Writes to rd=0 are dropped; x0 always reads 0.
  - Granted PE's bus_request=0 (no memory command):
    - grant=0 next cycle.
    - pc_out=PCoutBus, pc_valid pulses.
    - RR pointer = winner+1 mod NUM_PE; go to IDLE.
    - One idle cycle occurs between grants.
- MEM_WAIT: counter decrements; at 0 go to MEM_DONE. Total latency from command cycle to ack is MEM_LATENCY+1 cycles.
- MEM_DONE: perform the access, using word index = addr[31:2].
  - Write: mem[idx]=data.
  - Read: memData=mem[idx].
  - Index ≥ MEM_DEPTH: reads return 0, writes are dropped, ack still issued.
  - addr[1:0] is ignored.
  - mem_ackBus=1 for this cycle.
  - Next state: GRANTED if request still high, else the release sequence (grant=0, pc capture, IDLE).
- Request dropped during MEM_WAIT: the transaction completes and ack is issued; release follows.
- Request from a non-granted PE never preempts the current owner.
- Reset asserted mid-operation: immediate return to reset state. A pending write is discarded and no ack is issued.

Decomposition:
- Shared package pe_bus_pkg:
  - FSM state enum.
  - Register index width (5), data width (32).
  - reg_select encodings.
- One natural sub-module: rr_arbiter (NUM_PE requests, pointer, one-hot winner, combinational).
- Register file and memory arrays stay inline.

Test Plan:
1. Single-PE register access:
   - PE0 requests → grant=0001 next cycle.
   - rd_write rd=5, data 0xDEADBEEF, then read_en rs1=5, rs2=0, reg_select=1 → AmuxBus=0xDEADBEEF, BmuxBus=0, data_ReadyBus one-cycle pulse 1 cycle after read_en.
2. Round robin:
   - PE0–PE3 all request; each drops its request after one command.
   - Grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
   - pc_valid pulses at each release.
3. Memory write/read, MEM_LATENCY=2:
   - Write addr 0x10, data 0x12345678 → ack 3 cycles after command.
   - Read addr 0x10 → memData=0x12345678 with ack.
   - Read addr 0x13 → same word.
4. Boundary:
   - Write to addr 4*MEM_DEPTH → ack issued; a subsequent read there returns 0.
   - rd_write rd=0 with 0xFFFFFFFF → read rs1=0 gives 0.
   - mem_read and mem_write set together → write performed.
5. Release during MEM_WAIT:
   - PE1 issues a write and drops its request the next cycle → ack still pulses, then grant=0.
   - Read-back by another PE returns the written data.
6. Reset mid-op:
   - Assert reset in MEM_WAIT → grant, ack and data_Ready=0 immediately.
   - Write is not committed (prior memory value retained).
   - After release, arbitration restarts at PE0.
